// File: rtl/psum_accum_buffer.sv
// Multi-lane partial-sum accumulator with optional saturation, sticky
// per-lane overflow flags and a valid/ready result handshake.
module psum_accum_buffer #(
  parameter int BITWIDTH = 16,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int SATURATE = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [CNT_W-1:0]             i_len,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [CHANNELS*BITWIDTH-1:0] i_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [CHANNELS*BITWIDTH-1:0] o_result,
  output logic [CHANNELS-1:0]          o_overflow,
  output logic                         o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_HOLD
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic                        w_load;
  logic                        w_accept;
  logic [CNT_W-1:0]            r_remaining;
  logic [CHANNELS-1:0]         r_ovf;
  logic [CHANNELS-1:0]         w_lane_ovf;
  logic signed [BITWIDTH-1:0]  r_acc     [CHANNELS];
  logic signed [BITWIDTH-1:0]  w_acc_nxt [CHANNELS];
  logic signed [BITWIDTH-1:0]  w_lane    [CHANNELS];
  logic signed [BITWIDTH:0]    w_sum     [CHANNELS];

  // Next-state decode plus handshake outputs.
  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_accept = 1'b0;
    o_ready  = 1'b0;
    o_valid  = 1'b0;
    o_busy   = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (i_start && (i_len != '0)) begin
          w_load = 1'b1;
          w_next = S_ACCUM;
        end
      end
      S_ACCUM: begin
        o_ready = 1'b1;
        if (i_valid) begin
          w_accept = 1'b1;
          if (r_remaining == CNT_W'(1)) begin
            w_next = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        o_valid = 1'b1;
        if (i_ready) begin
          // A start coinciding with the handshake reloads without an idle bubble.
          if (i_start && (i_len != '0)) begin
            w_load = 1'b1;
            w_next = S_ACCUM;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Per-lane widened add with overflow detect and optional clamp.
  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      w_lane[c]     = i_data[c*BITWIDTH +: BITWIDTH];
      w_sum[c]      = {r_acc[c][BITWIDTH-1], r_acc[c]} + {w_lane[c][BITWIDTH-1], w_lane[c]};
      w_lane_ovf[c] = (w_sum[c][BITWIDTH] != w_sum[c][BITWIDTH-1]);
      if (w_lane_ovf[c] && (SATURATE != 0)) begin
        w_acc_nxt[c] = w_sum[c][BITWIDTH] ? {1'b1, {(BITWIDTH-1){1'b0}}}
                                          : {1'b0, {(BITWIDTH-1){1'b1}}};
      end else begin
        w_acc_nxt[c] = w_sum[c][BITWIDTH-1:0];
      end
    end
  end

  // State, beat counter, accumulators and sticky overflow flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_ovf       <= '0;
      r_acc       <= '{default: '0};
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_remaining <= i_len;
        r_ovf       <= '0;
        r_acc       <= '{default: '0};
      end else if (w_accept) begin
        r_remaining <= r_remaining - CNT_W'(1);
        r_ovf       <= r_ovf | w_lane_ovf;
        r_acc       <= w_acc_nxt;
      end
    end
  end

  // Pack the accumulator registers onto the result bus.
  always_comb begin
    o_result = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      o_result[c*BITWIDTH +: BITWIDTH] = r_acc[c];
    end
  end

  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_psum_accum_buffer.sv
// Bench for psum_accum_buffer: a saturating and a wrapping instance share
// stimulus and are compared against an integer-arithmetic reference model.
module tb_psum_accum_buffer;

  localparam int BW = 16;
  localparam int CH = 4;
  localparam int CW = 8;
  localparam int MAXV = 32767;
  localparam int MINV = -32768;
  localparam int M_IDLE = 0, M_ACCUM = 1, M_HOLD = 2;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_start;
  logic [CW-1:0]    i_len;
  logic             i_valid;
  logic             i_ready;
  logic [CH*BW-1:0] i_data;

  logic             o_ready_s, o_valid_s, o_busy_s;
  logic [CH*BW-1:0] o_result_s;
  logic [CH-1:0]    o_overflow_s;
  logic             o_ready_w, o_valid_w, o_busy_w;
  logic [CH*BW-1:0] o_result_w;
  logic [CH-1:0]    o_overflow_w;

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  int            m_state;
  int            m_rem;
  int            m_acc_s [CH];
  int            m_acc_w [CH];
  logic [CH-1:0] m_ovf_s;
  logic [CH-1:0] m_ovf_w;

  always #5 i_clk = ~i_clk;

  psum_accum_buffer #(.BITWIDTH(BW), .CHANNELS(CH), .CNT_W(CW), .SATURATE(1)) dut_sat (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_len(i_len),
    .i_valid(i_valid), .o_ready(o_ready_s), .i_data(i_data), .o_valid(o_valid_s),
    .i_ready(i_ready), .o_result(o_result_s), .o_overflow(o_overflow_s), .o_busy(o_busy_s)
  );

  psum_accum_buffer #(.BITWIDTH(BW), .CHANNELS(CH), .CNT_W(CW), .SATURATE(0)) dut_wrap (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_len(i_len),
    .i_valid(i_valid), .o_ready(o_ready_w), .i_data(i_data), .o_valid(o_valid_w),
    .i_ready(i_ready), .o_result(o_result_w), .o_overflow(o_overflow_w), .o_busy(o_busy_w)
  );

  task automatic model_reset();
    m_state = M_IDLE;
    m_rem   = 0;
    m_ovf_s = '0;
    m_ovf_w = '0;
    for (int c = 0; c < CH; c++) begin
      m_acc_s[c] = 0;
      m_acc_w[c] = 0;
    end
  endtask

  task automatic model_load();
    model_reset();
    m_rem   = int'(i_len);
    m_state = M_ACCUM;
  endtask

  task automatic model_beat();
    for (int c = 0; c < CH; c++) begin
      logic signed [BW-1:0] v;
      int x, s, w;
      v = i_data[c*BW +: BW];
      x = int'(v);
      s = m_acc_s[c] + x;
      if (s > MAXV) begin s = MAXV; m_ovf_s[c] = 1'b1; end
      else if (s < MINV) begin s = MINV; m_ovf_s[c] = 1'b1; end
      m_acc_s[c] = s;
      w = m_acc_w[c] + x;
      if (w > MAXV) begin w = w - 65536; m_ovf_w[c] = 1'b1; end
      else if (w < MINV) begin w = w + 65536; m_ovf_w[c] = 1'b1; end
      m_acc_w[c] = w;
    end
  endtask

  function automatic logic [CH*BW-1:0] model_result(input bit sat);
    logic [CH*BW-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      r[c*BW +: BW] = sat ? 16'(m_acc_s[c]) : 16'(m_acc_w[c]);
    end
    return r;
  endfunction

  // Apply the current inputs across one rising edge and advance the model.
  task automatic cycle();
    case (m_state)
      M_IDLE:  if (i_start && i_len != 0) model_load();
      M_ACCUM: if (i_valid) begin
                 model_beat();
                 m_rem--;
                 if (m_rem == 0) m_state = M_HOLD;
               end
      M_HOLD:  if (i_ready) begin
                 if (i_start && i_len != 0) model_load();
                 else m_state = M_IDLE;
               end
      default: m_state = M_IDLE;
    endcase
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_start = 0; i_len = 0; i_valid = 0; i_ready = 0; i_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rst = 1'b1;
    model_reset();
    #2;
    n_checks++;
    if ({o_valid_s, o_ready_s, o_busy_s, o_overflow_s, o_result_s} !== '0) begin
      n_errors++;
      $display("FAIL reset_sat: got v%b r%b b%b ovf %b res %h, expected all zero",
               o_valid_s, o_ready_s, o_busy_s, o_overflow_s, o_result_s);
    end
    n_checks++;
    if ({o_valid_w, o_ready_w, o_busy_w, o_overflow_w, o_result_w} !== '0) begin
      n_errors++;
      $display("FAIL reset_wrap: got v%b r%b b%b ovf %b res %h, expected all zero",
               o_valid_w, o_ready_w, o_busy_w, o_overflow_w, o_result_w);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_basic();
    i_start = 1; i_len = 3;
    cycle();
    i_start = 0;
    n_checks++;
    if (o_ready_s !== 1'b1 || o_busy_s !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_accum_state: ready %b busy %b, expected 1 1", o_ready_s, o_busy_s);
    end
    for (int b = 0; b < 3; b++) begin
      i_valid = 1;
      i_data  = {16'd4, 16'd3, 16'd2, 16'd1};
      cycle();
      if (b < 2) begin
        n_checks++;
        if (o_valid_s !== 1'b0) begin
          n_errors++;
          $display("FAIL basic_early_valid: beat %0d o_valid %b, expected 0", b, o_valid_s);
        end
      end
    end
    i_valid = 0;
    n_checks++;
    if (o_valid_s !== 1'b1 || o_ready_s !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_latency: valid %b ready %b, expected 1 0", o_valid_s, o_ready_s);
    end
    n_checks++;
    if (o_result_s !== {16'd12, 16'd9, 16'd6, 16'd3} || o_overflow_s !== 4'b0000) begin
      n_errors++;
      $display("FAIL basic_result: got %h ovf %b, expected %h ovf 0000",
               o_result_s, o_overflow_s, {16'd12, 16'd9, 16'd6, 16'd3});
    end
    n_checks++;
    if (o_result_w !== {16'd12, 16'd9, 16'd6, 16'd3}) begin
      n_errors++;
      $display("FAIL basic_result_wrap: got %h, expected %h", o_result_w, {16'd12, 16'd9, 16'd6, 16'd3});
    end
    i_ready = 1;
    cycle();
    i_ready = 0;
    n_checks++;
    if (o_valid_s !== 1'b0 || o_busy_s !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_release: valid %b busy %b, expected 0 0", o_valid_s, o_busy_s);
    end
  endtask

  task automatic test_stalls();
    int n;
    logic [CH*BW-1:0] held;
    i_start = 1; i_len = 3;
    cycle();
    i_start = 0;
    n = 0;
    while (m_state != M_HOLD && n < 100) begin
      i_valid = 1'($urandom_range(0, 1));
      i_data  = {16'd4, 16'd3, 16'd2, 16'd1};
      cycle();
      n++;
    end
    i_valid = 0;
    n_checks++;
    if (o_valid_s !== 1'b1) begin
      n_errors++;
      $display("FAIL stalls_timeout: o_valid %b after %0d cycles, expected 1", o_valid_s, n);
    end
    held = o_result_s;
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_data  = {$urandom, $urandom};
      cycle();
      n_checks++;
      if (o_valid_s !== 1'b1 || o_ready_s !== 1'b0 || o_result_s !== held ||
          o_result_s !== {16'd12, 16'd9, 16'd6, 16'd3}) begin
        n_errors++;
        $display("FAIL stalls_hold: cycle %0d valid %b ready %b res %h, expected 1 0 %h",
                 k, o_valid_s, o_ready_s, o_result_s, {16'd12, 16'd9, 16'd6, 16'd3});
      end
    end
    i_valid = 0;
    i_ready = 1;
    cycle();
    i_ready = 0;
  endtask

  task automatic test_saturate();
    i_start = 1; i_len = 2;
    cycle();
    i_start = 0;
    i_valid = 1;
    i_data  = {16'h0000, 16'h0000, 16'h9000, 16'h7000};
    cycle();
    cycle();
    i_valid = 0;
    n_checks++;
    if (o_result_s !== {16'h0000, 16'h0000, 16'h8000, 16'h7FFF} || o_overflow_s !== 4'b0011) begin
      n_errors++;
      $display("FAIL saturate_sat: got %h ovf %b, expected 0000000080007fff ovf 0011",
               o_result_s, o_overflow_s);
    end
    n_checks++;
    if (o_result_w !== {16'h0000, 16'h0000, 16'h2000, 16'hE000} || o_overflow_w !== 4'b0011) begin
      n_errors++;
      $display("FAIL saturate_wrap: got %h ovf %b, expected 000000002000e000 ovf 0011",
               o_result_w, o_overflow_w);
    end
    i_ready = 1;
    cycle();
    i_ready = 0;
  endtask

  task automatic test_back_to_back();
    i_start = 1; i_len = 2;
    cycle();
    i_start = 0;
    i_valid = 1;
    for (int b = 0; b < 2; b++) begin
      i_data = {$urandom, $urandom};
      cycle();
    end
    i_valid = 0;
    i_ready = 1; i_start = 1; i_len = 2;
    cycle();
    i_ready = 0; i_start = 0;
    n_checks++;
    if (o_ready_s !== 1'b1 || o_valid_s !== 1'b0 || o_result_s !== '0 || o_overflow_s !== '0) begin
      n_errors++;
      $display("FAIL b2b_reload: ready %b valid %b res %h ovf %b, expected 1 0 zero zero",
               o_ready_s, o_valid_s, o_result_s, o_overflow_s);
    end
    i_valid = 1;
    for (int b = 0; b < 2; b++) begin
      i_data = {16'($urandom_range(0, 2000)), 16'($urandom_range(0, 2000)),
                16'($urandom_range(0, 2000)), 16'($urandom_range(0, 2000))};
      cycle();
    end
    i_valid = 0;
    n_checks++;
    if (o_valid_s !== 1'b1 || o_result_s !== model_result(1'b1) || o_overflow_s !== m_ovf_s) begin
      n_errors++;
      $display("FAIL b2b_second_sum: valid %b res %h ovf %b, expected 1 %h %b",
               o_valid_s, o_result_s, o_overflow_s, model_result(1'b1), m_ovf_s);
    end
    i_ready = 1;
    cycle();
    i_ready = 0;
  endtask

  task automatic test_ignored();
    i_start = 1; i_len = 0;
    cycle();
    i_start = 0;
    n_checks++;
    if (o_busy_s !== 1'b0 || o_ready_s !== 1'b0) begin
      n_errors++;
      $display("FAIL ignored_len0: busy %b ready %b, expected 0 0", o_busy_s, o_ready_s);
    end
    i_start = 1; i_len = 3;
    cycle();
    i_start = 0;
    i_valid = 1; i_data = {16'd40, 16'd30, 16'd20, 16'd10};
    cycle();
    i_valid = 0; i_start = 1; i_len = 1;
    cycle();
    i_start = 1; i_len = 5; i_valid = 1; i_data = {16'd1, 16'd1, 16'd1, 16'd1};
    cycle();
    i_start = 0;
    n_checks++;
    if (o_valid_s !== 1'b0 || o_ready_s !== 1'b1) begin
      n_errors++;
      $display("FAIL ignored_mid_accum: valid %b ready %b after 2 of 3 beats, expected 0 1",
               o_valid_s, o_ready_s);
    end
    i_data = {16'd2, 16'd2, 16'd2, 16'd2};
    cycle();
    i_valid = 0;
    i_start = 1; i_len = 4;
    cycle();
    i_start = 0;
    n_checks++;
    if (o_valid_s !== 1'b1 || o_result_s !== {16'd43, 16'd33, 16'd23, 16'd13}) begin
      n_errors++;
      $display("FAIL ignored_result: valid %b res %h, expected 1 %h",
               o_valid_s, o_result_s, {16'd43, 16'd33, 16'd23, 16'd13});
    end
    i_ready = 1;
    cycle();
    i_ready = 0;
  endtask

  task automatic test_reset_mid();
    i_start = 1; i_len = 3;
    cycle();
    i_start = 0;
    i_valid = 1; i_data = {16'd5, 16'd6, 16'd7, 16'd8};
    cycle();
    i_valid = 0;
    #3;
    i_rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({o_valid_s, o_ready_s, o_busy_s, o_overflow_s, o_result_s} !== '0 ||
        {o_valid_w, o_ready_w, o_busy_w, o_overflow_w, o_result_w} !== '0) begin
      n_errors++;
      $display("FAIL reset_async: sat busy %b ready %b res %h, wrap res %h, expected zero",
               o_busy_s, o_ready_s, o_result_s, o_result_w);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    n_checks++;
    if (o_busy_s !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle: busy %b, expected 0", o_busy_s);
    end
    i_start = 1; i_len = 2;
    cycle();
    i_start = 0; i_valid = 1;
    for (int b = 0; b < 2; b++) begin
      i_data = {$urandom, $urandom};
      cycle();
    end
    i_valid = 0;
    n_checks++;
    if (o_valid_s !== 1'b1 || o_result_s !== model_result(1'b1) || o_result_w !== model_result(1'b0)) begin
      n_errors++;
      $display("FAIL reset_rerun: valid %b res %h/%h, expected 1 %h/%h", o_valid_s,
               o_result_s, o_result_w, model_result(1'b1), model_result(1'b0));
    end
    i_ready = 1;
    cycle();
    i_ready = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      i_start = ($urandom_range(0, 3) == 0);
      i_len   = CW'($urandom_range(0, 6));
      i_valid = 1'($urandom_range(0, 1));
      i_ready = 1'($urandom_range(0, 1));
      i_data  = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom}
              : {16'($urandom_range(0, 600)), 16'($urandom_range(0, 600)),
                 16'($urandom_range(0, 600)), 16'($urandom_range(0, 600))};
      cycle();
      n_checks++;
      if (o_valid_s !== (m_state == M_HOLD) || o_ready_s !== (m_state == M_ACCUM) ||
          o_busy_s !== (m_state != M_IDLE) || o_result_s !== model_result(1'b1) ||
          o_overflow_s !== m_ovf_s) begin
        n_errors++;
        $display("FAIL random_sat: cyc %0d v%b r%b b%b res %h ovf %b, expected state %0d res %h ovf %b",
                 k, o_valid_s, o_ready_s, o_busy_s, o_result_s, o_overflow_s,
                 m_state, model_result(1'b1), m_ovf_s);
      end
      n_checks++;
      if (o_valid_w !== (m_state == M_HOLD) || o_result_w !== model_result(1'b0) ||
          o_overflow_w !== m_ovf_w) begin
        n_errors++;
        $display("FAIL random_wrap: cyc %0d v%b res %h ovf %b, expected state %0d res %h ovf %b",
                 k, o_valid_w, o_result_w, o_overflow_w, m_state, model_result(1'b0), m_ovf_w);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_saturate();
    test_back_to_back();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
